intr_sync_ctrl: RTL and testbench

Multi-channel successor to the single-line interrupt synchronizer. It has these stages:
- NUM_INTR asynchronous interrupt inputs, each through a SYNC_STAGES-deep dffrl_ns chain.
- Per-channel polarity and edge/level mode.
- Edge-pending latches with clear, and per-channel mask.
- Fixed-priority arbitration to a single registered request/ID with acknowledge handshake.

It sits between external pins and the core's interrupt/exception logic.

---
 rtl/intr_sync_ctrl.sv | 169 ++++++++++++++++
 tb/tb_intr_sync_ctrl.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/intr_sync_ctrl.sv
// intr_sync_ctrl: multi-channel interrupt synchronizer and controller.
//
// Each asynchronous interrupt line runs through a SYNC_STAGES-deep reset flop
// chain. The synchronized level is optionally glitch-filtered, then
// polarity-adjusted. The result either latches as an edge-pending bit or is
// tracked as a level. Finally it is masked and fixed-priority arbitrated into
// one registered request/ID pair, which is retired by an acknowledge.
//
// Optional feature macro: INTR_SYNC_FILTER_EN.
//   Defined:   per-channel glitch filter of FILTER_CYCLES consecutive cycles.
//   Undefined: no filter; the filtered level is the synchronizer output.
//
// Ports:
//   clk, rst_n    - clock, asynchronous active-low reset
//   intr          - asynchronous interrupt lines
//   intr_pol      - 1 = active-high/rising, 0 = active-low/falling
//   intr_mode     - 1 = edge-triggered, 0 = level-triggered
//   intr_mask     - 1 = channel may raise intr_req
//   intr_clr      - one-cycle pulse, clears edge-pending bits
//   intr_ack      - acknowledge of the presented intr_id
//   intr_sync     - synchronized (filtered) raw levels, before polarity
//   intr_pending  - pending status, unmasked
//   intr_req      - registered: any enabled channel pending
//   intr_id       - registered: lowest-index enabled pending channel
module intr_sync_ctrl #(
  parameter int unsigned NUM_INTR      = 8,
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned ID_W          = 3,
  parameter int unsigned FILTER_CYCLES = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_INTR-1:0] intr,
  input  logic [NUM_INTR-1:0] intr_pol,
  input  logic [NUM_INTR-1:0] intr_mode,
  input  logic [NUM_INTR-1:0] intr_mask,
  input  logic [NUM_INTR-1:0] intr_clr,
  input  logic                intr_ack,
  output logic [NUM_INTR-1:0] intr_sync,
  output logic [NUM_INTR-1:0] intr_pending,
  output logic                intr_req,
  output logic [ID_W-1:0]     intr_id
);

  // Elaboration-time parameter sanity checks.
  if (NUM_INTR < 1 || NUM_INTR > 32) begin : g_chk_num_intr
    $error("intr_sync_ctrl: NUM_INTR must be 1..32");
  end
  if (SYNC_STAGES < 2) begin : g_chk_sync
    $error("intr_sync_ctrl: SYNC_STAGES must be >= 2");
  end
  if (ID_W < 1 || (64'd1 << ID_W) < 64'(NUM_INTR)) begin : g_chk_id_w
    $error("intr_sync_ctrl: ID_W too small for NUM_INTR");
  end
  if (FILTER_CYCLES < 1 || FILTER_CYCLES > 255) begin : g_chk_filter
    $error("intr_sync_ctrl: FILTER_CYCLES must be 1..255");
  end

  // Synchronizer chains: stage 0 samples the pins, last stage is the clean level.
  logic [SYNC_STAGES-1:0][NUM_INTR-1:0] sync_q;
  logic [NUM_INTR-1:0]                  sync_lvl;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], intr};
    end
  end

  assign sync_lvl = sync_q[SYNC_STAGES-1];

  logic [NUM_INTR-1:0] filt_lvl;

`ifdef INTR_SYNC_FILTER_EN
  localparam int unsigned    CntW   = $clog2(FILTER_CYCLES + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(FILTER_CYCLES);

  logic [NUM_INTR-1:0][CntW-1:0] cnt_q, cnt_d;
  logic [NUM_INTR-1:0]           filt_q, filt_d;

  // Count consecutive cycles where the synced level disagrees with the filtered
  // one; the FILTER_CYCLES-th disagreeing sample flips the filtered level.
  always_comb begin
    cnt_d  = cnt_q;
    filt_d = filt_q;
    for (int i = 0; i < int'(NUM_INTR); i++) begin
      if (sync_lvl[i] == filt_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CntMax - 1'b1) begin
        cnt_d[i]  = '0;
        filt_d[i] = sync_lvl[i];
      end else begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      filt_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      filt_q <= filt_d;
    end
  end

  assign filt_lvl = filt_q;
`else
  assign filt_lvl = sync_lvl;
`endif

  // Polarity and edge detection.
  logic [NUM_INTR-1:0] act, act_q, edge_det;
  assign act      = ~(filt_lvl ^ intr_pol);
  assign edge_det = act & ~act_q;

  // Pending bits.
  logic [NUM_INTR-1:0] pend_q, pend_d, clr;
  logic                req_q, req_d;
  logic [ID_W-1:0]     id_q, id_d;

  // Ack retires only the channel currently presented, and only while requesting.
  always_comb begin
    clr = '0;
    for (int i = 0; i < int'(NUM_INTR); i++) begin
      clr[i] = intr_clr[i] | (intr_ack & req_q & (id_q == ID_W'(i)));
    end
  end

  // Edge mode: a new edge beats a coincident clear. Level mode: track act, which
  // also discards any latched edge when a channel switches to level.
  assign pend_d = (intr_mode & (edge_det | (pend_q & ~clr))) | (~intr_mode & act);

  // Arbitration over enabled pending channels; descending loop so lowest wins.
  logic [NUM_INTR-1:0] en;
  assign en    = pend_q & intr_mask;
  assign req_d = |en;

  always_comb begin
    id_d = '0;
    for (int i = int'(NUM_INTR) - 1; i >= 0; i--) begin
      if (en[i]) begin
        id_d = ID_W'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_q  <= '0;
      pend_q <= '0;
      req_q  <= 1'b0;
      id_q   <= '0;
    end else begin
      act_q  <= act;
      pend_q <= pend_d;
      req_q  <= req_d;
      id_q   <= id_d;
    end
  end

  assign intr_sync    = filt_lvl;
  assign intr_pending = pend_q;
  assign intr_req     = req_q;
  assign intr_id      = id_q;

endmodule

// File: tb/tb_intr_sync_ctrl.sv
module tb_intr_sync_ctrl;

  localparam int N = 8;
`ifdef INTR_SYNC_FILTER_EN
  localparam int FD = 4;
`else
  localparam int FD = 0;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] intr, intr_pol, intr_mode, intr_mask, intr_clr;
  logic         intr_ack;
  logic [N-1:0] intr_sync, intr_pending;
  logic         intr_req;
  logic [2:0]   intr_id;

  intr_sync_ctrl #(
    .NUM_INTR     (N),
    .SYNC_STAGES  (2),
    .ID_W         (3),
    .FILTER_CYCLES(4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .intr        (intr),
    .intr_pol    (intr_pol),
    .intr_mode   (intr_mode),
    .intr_mask   (intr_mask),
    .intr_clr    (intr_clr),
    .intr_ack    (intr_ack),
    .intr_sync   (intr_sync),
    .intr_pending(intr_pending),
    .intr_req    (intr_req),
    .intr_id     (intr_id)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    logic       req;
    logic [2:0] id;
    logic [7:0] pend;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  // Advance n rising edges, then settle 1 time unit past the edge.
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic expect_out(input string tag, input logic req, input logic [2:0] id,
                            input logic [7:0] pend);
    exp_t e;
    e.tag  = tag;
    e.req  = req;
    e.id   = id;
    e.pend = pend;
    sb.push_back(e);
  endtask

  task automatic check_out();
    exp_t e;
    if (sb.size() == 0) begin
      n_chk++;
      $error("FAIL sb_underflow: observed empty queue expected an entry");
    end else begin
      e = sb.pop_front();
      chk({e.tag, ".req"},  32'(intr_req),     32'(e.req));
      chk({e.tag, ".id"},   32'(intr_id),      32'(e.id));
      chk({e.tag, ".pend"}, 32'(intr_pending), 32'(e.pend));
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    intr      = '0;
    intr_pol  = 8'hFF;
    intr_mode = 8'hFF;
    intr_mask = 8'hFF;
    intr_clr  = '0;
    intr_ack  = 1'b0;

    // Reset state
    #2;
    expect_out("reset", 1'b0, 3'd0, 8'h00);
    check_out();
    chk("reset.sync", 32'(intr_sync), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    expect_out("post_reset", 1'b0, 3'd0, 8'h00);
    cyc(3);
    check_out();

    // Edge latency on ch3
    intr[3] = 1'b1;
    expect_out("t1_sync", 1'b0, 3'd0, 8'h00);
    cyc(FD + 2);
    check_out();
    chk("t1_sync.bit", 32'(intr_sync), 32'h08);
    expect_out("t1_pend", 1'b0, 3'd0, 8'h08);
    cyc(1);
    check_out();
    expect_out("t1_req", 1'b1, 3'd3, 8'h08);
    cyc(1);
    check_out();
    intr_ack = 1'b1;
    expect_out("t1_ack", 1'b1, 3'd3, 8'h00);
    cyc(1);
    intr_ack = 1'b0;
    check_out();
    expect_out("t1_req_drop", 1'b0, 3'd0, 8'h00);
    cyc(1);
    check_out();
    expect_out("t1_held", 1'b0, 3'd0, 8'h00);
    cyc(4);
    check_out();
    intr[3] = 1'b0;
    cyc(FD + 4);

    // Priority: simultaneous edges on ch5 and ch2
    intr[5] = 1'b1;
    intr[2] = 1'b1;
    expect_out("t2_first", 1'b1, 3'd2, 8'h24);
    cyc(FD + 4);
    check_out();
    intr_ack = 1'b1;
    expect_out("t2_ack1", 1'b1, 3'd2, 8'h20);
    cyc(1);
    intr_ack = 1'b0;
    check_out();
    expect_out("t2_second", 1'b1, 3'd5, 8'h20);
    cyc(1);
    check_out();
    intr_ack = 1'b1;
    expect_out("t2_ack2", 1'b1, 3'd5, 8'h00);
    cyc(1);
    intr_ack = 1'b0;
    check_out();
    expect_out("t2_idle", 1'b0, 3'd0, 8'h00);
    cyc(1);
    check_out();
    intr[5] = 1'b0;
    intr[2] = 1'b0;
    cyc(FD + 4);

    // Level mode, active-low on ch1
    intr_mask = 8'hFD;
    intr[1]   = 1'b1;
    expect_out("t3_masked_edge", 1'b0, 3'd0, 8'h02);
    cyc(FD + 3);
    check_out();
    intr_mode[1] = 1'b0;
    intr_pol[1]  = 1'b0;
    expect_out("t3_mode_discard", 1'b0, 3'd0, 8'h00);
    cyc(1);
    check_out();
    intr_mask = 8'hFF;
    expect_out("t3_unmask_idle", 1'b0, 3'd0, 8'h00);
    cyc(2);
    check_out();
    intr[1] = 1'b0;
    expect_out("t3_level_req", 1'b1, 3'd1, 8'h02);
    cyc(FD + 4);
    check_out();
    intr_ack = 1'b1;
    expect_out("t3_ack_ignored", 1'b1, 3'd1, 8'h02);
    cyc(2);
    intr_ack = 1'b0;
    check_out();
    intr[1] = 1'b1;
    expect_out("t3_pend_drop", 1'b1, 3'd1, 8'h00);
    cyc(FD + 3);
    check_out();
    expect_out("t3_req_drop", 1'b0, 3'd0, 8'h00);
    cyc(1);
    check_out();
    // Back to edge/high on a held line: polarity flip latches a stale edge.
    intr_mask    = 8'hFD;
    intr_mode[1] = 1'b1;
    intr_pol[1]  = 1'b1;
    expect_out("t3_polflip_edge", 1'b0, 3'd0, 8'h02);
    cyc(1);
    check_out();
    intr_clr[1] = 1'b1;
    expect_out("t3_clr", 1'b0, 3'd0, 8'h00);
    cyc(1);
    intr_clr = '0;
    check_out();
    intr[1] = 1'b0;
    cyc(FD + 4);
    intr_mask = 8'hFF;

    // Clear/mask race on ch0
    intr_mask = 8'hFE;
    intr[0]   = 1'b1;
    expect_out("t4_masked_pend", 1'b0, 3'd0, 8'h01);
    cyc(FD + 3);
    check_out();
    intr_ack = 1'b1;
    expect_out("t4_ack_noreq", 1'b0, 3'd0, 8'h01);
    cyc(1);
    intr_ack = 1'b0;
    check_out();
    intr[0]     = 1'b0;
    intr_clr[0] = 1'b1;
    expect_out("t4_clr", 1'b0, 3'd0, 8'h00);
    cyc(1);
    intr_clr = '0;
    check_out();
    cyc(FD + 3);
    intr[0] = 1'b1;
    cyc(FD + 2);
    intr_clr[0] = 1'b1;
    expect_out("t4_race", 1'b0, 3'd0, 8'h01);
    cyc(1);
    intr_clr = '0;
    check_out();
    intr_mask = 8'hFF;
    expect_out("t4_unmask", 1'b1, 3'd0, 8'h01);
    cyc(1);
    check_out();
    intr_ack = 1'b1;
    expect_out("t4_ack", 1'b1, 3'd0, 8'h00);
    cyc(1);
    intr_ack = 1'b0;
    check_out();
    expect_out("t4_idle", 1'b0, 3'd0, 8'h00);
    cyc(1);
    check_out();
    intr[0] = 1'b0;
    cyc(FD + 4);

`ifdef INTR_SYNC_FILTER_EN
    // Glitch filter on ch6
    intr[6] = 1'b1;
    cyc(3);
    intr[6] = 1'b0;
    expect_out("t5_glitch", 1'b0, 3'd0, 8'h00);
    cyc(12);
    check_out();
    intr[6] = 1'b1;
    cyc(4);
    intr[6] = 1'b0;
    expect_out("t5_pre", 1'b0, 3'd0, 8'h00);
    cyc(2);
    check_out();
    expect_out("t5_pend", 1'b0, 3'd0, 8'h40);
    cyc(1);
    check_out();
    expect_out("t5_req", 1'b1, 3'd6, 8'h40);
    cyc(1);
    check_out();
    intr_clr[6] = 1'b1;
    cyc(1);
    intr_clr = '0;
    expect_out("t5_idle", 1'b0, 3'd0, 8'h00);
    cyc(8);
    check_out();
`endif

    // Asynchronous reset mid-traffic
    intr[7] = 1'b1;
    expect_out("t6_busy", 1'b1, 3'd7, 8'h80);
    cyc(FD + 4);
    check_out();
    #2;
    rst_n = 1'b0;
    intr  = '0;
    #1;
    expect_out("t6_async_reset", 1'b0, 3'd0, 8'h00);
    check_out();
    chk("t6_async_reset.sync", 32'(intr_sync), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    expect_out("t6_after", 1'b0, 3'd0, 8'h00);
    cyc(6);
    check_out();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
